// File: rtl/seq_detect_param_pkg.sv
// Shared constants and helpers for the parametrised serial pattern detector.
// Imported by the interface, the top module and the match counter.
package seq_detect_pkg;

  localparam logic MEALY = 1'b0;
  localparam logic MOORE = 1'b1;

  localparam logic [3:0] SEQ_PAT_DEFAULT = 4'b1001;

  // Width of the fill counter: it must hold 0..pat_w-1.
  function automatic int fill_w(input int pat_w);
    return $clog2(pat_w);
  endfunction

endpackage

// File: rtl/seq_detect_param_if.sv
// Bit-stream, mode and pattern-load signals of seq_detect_param.
// match_cnt (and the CNT_W parameter) exist only when SEQ_MATCH_CNT_EN is defined.
interface seq_detect_param_if #(
  parameter int PAT_W = 4
`ifdef SEQ_MATCH_CNT_EN
  ,
  parameter int CNT_W = 8
`endif
) ();

  logic             Data_in;
  logic             valid;
  logic             MACHINE;
  logic             OVERLAP;
  logic             pat_load;
  logic [PAT_W-1:0] pat_in;
  logic             out;
`ifdef SEQ_MATCH_CNT_EN
  logic [CNT_W-1:0] match_cnt;
`endif

`ifdef SEQ_MATCH_CNT_EN
  modport master (
    output Data_in, valid, MACHINE, OVERLAP, pat_load, pat_in,
    input  out, match_cnt
  );

  modport slave (
    input  Data_in, valid, MACHINE, OVERLAP, pat_load, pat_in,
    output out, match_cnt
  );
`else
  modport master (
    output Data_in, valid, MACHINE, OVERLAP, pat_load, pat_in,
    input  out
  );

  modport slave (
    input  Data_in, valid, MACHINE, OVERLAP, pat_load, pat_in,
    output out
  );
`endif

endinterface

// File: rtl/seq_match_cnt.sv
// Saturating match counter for seq_detect_param; cleared by reset or a pattern load.
// Only instantiated when SEQ_MATCH_CNT_EN is defined.
module seq_match_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Clear wins over increment; all-ones is the saturation point.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/seq_detect_param.sv
// Run-time loadable PAT_W-bit serial pattern detector with Mealy/Moore output select
// and overlap control. Define SEQ_MATCH_CNT_EN to add the saturating match counter.
module seq_detect_param
  import seq_detect_pkg::*;
#(
  parameter int               PAT_W   = 4,
  parameter int               CNT_W   = 8,
  parameter logic [PAT_W-1:0] PAT_RST = PAT_W'(SEQ_PAT_DEFAULT)
) (
  input  logic            clk,
  input  logic            rst,
  seq_detect_param_if.slave bus
);

  localparam int               FILL_W   = fill_w(PAT_W);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);

  if ((PAT_W < 2) || (PAT_W > 32)) begin : g_bad_pat_w
    $error("seq_detect_param: PAT_W must be in 2..32");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("seq_detect_param: CNT_W must be at least 1");
  end

  logic [PAT_W-1:0]  pat_q;
  logic [PAT_W-1:0]  pat_d;
  logic [PAT_W-2:0]  hist_q;
  logic [PAT_W-2:0]  hist_d;
  logic [FILL_W-1:0] fill_q;
  logic [FILL_W-1:0] fill_d;
  logic              moore_q;
  logic              moore_d;
  logic [PAT_W-1:0]  window;
  logic              hit;

  always_comb begin
    window  = {hist_q, bus.Data_in};
    hit     = bus.valid & (fill_q == FILL_MAX) & (window == pat_q) & ~bus.pat_load;
    pat_d   = pat_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    moore_d = hit;

    // A pattern load restarts detection and drops any bit offered in the same cycle.
    if (bus.pat_load) begin
      pat_d   = bus.pat_in;
      fill_d  = '0;
      moore_d = 1'b0;
    end else if (bus.valid) begin
      hist_d = window[PAT_W-2:0];
      if (hit && !bus.OVERLAP) begin
        fill_d = '0;
      end else if (fill_q != FILL_MAX) begin
        fill_d = fill_q + FILL_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q   <= PAT_RST;
      hist_q  <= '0;
      fill_q  <= '0;
      moore_q <= 1'b0;
    end else begin
      pat_q   <= pat_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      moore_q <= moore_d;
    end
  end

  // moore_q always tracks hit, so MACHINE only steers the output mux.
  assign bus.out = (bus.MACHINE == MOORE) ? moore_q : hit;

`ifdef SEQ_MATCH_CNT_EN
  logic [CNT_W-1:0] match_cnt;

  seq_match_cnt #(
    .CNT_W (CNT_W)
  ) u_match_cnt (
    .clk (clk),
    .rst (rst),
    .clr (bus.pat_load),
    .inc (hit),
    .cnt (match_cnt)
  );

  assign bus.match_cnt = match_cnt;
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
// Scoreboard bench for seq_detect_param: a 4-bit/8-bit-counter instance (A) and a
// 2-bit/2-bit-counter instance (B) driven from directed, hand-computed vectors.
module tb_seq_detect_param;
  import seq_detect_pkg::*;

  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef SEQ_MATCH_CNT_EN
  seq_detect_param_if #(.PAT_W(4), .CNT_W(8)) bus_a ();
  seq_detect_param_if #(.PAT_W(2), .CNT_W(2)) bus_b ();
`else
  seq_detect_param_if #(.PAT_W(4)) bus_a ();
  seq_detect_param_if #(.PAT_W(2)) bus_b ();
`endif

  seq_detect_param #(.PAT_W(4), .CNT_W(8), .PAT_RST(4'b1001)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  seq_detect_param #(.PAT_W(2), .CNT_W(2), .PAT_RST(2'b11)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  typedef struct packed {
    logic sel;
    logic e;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_x;
  logic mon_act;
  int   n_pass  = 0;
  int   n_total = 0;
  int   cyc_no  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc_no);
  endtask

  // Monitor: the DUT presents out every cycle; compare against the queued expectation.
  always @(negedge clk) begin
    #2;
    if (sb_q.size() > 0) begin
      mon_x   = sb_q.pop_front();
      mon_act = mon_x.sel ? bus_b.out : bus_a.out;
      check(mon_x.sel ? "out_b" : "out_a", {31'd0, mon_act}, {31'd0, mon_x.e});
    end
  end

  task automatic cyc(input bit sel, input bit r, input bit d, input bit v, input bit m,
                     input bit ov, input bit ld, input logic [3:0] p, input bit chk,
                     input bit e);
    @(negedge clk);
    cyc_no++;
    rst = r;
    if (!sel) begin
      bus_a.Data_in = d; bus_a.valid = v; bus_a.MACHINE = m; bus_a.OVERLAP = ov;
      bus_a.pat_load = ld; bus_a.pat_in = p;
      bus_b.valid = 1'b0; bus_b.pat_load = 1'b0;
    end else begin
      bus_b.Data_in = d; bus_b.valid = v; bus_b.MACHINE = m; bus_b.OVERLAP = ov;
      bus_b.pat_load = ld; bus_b.pat_in = p[1:0];
      bus_a.valid = 1'b0; bus_a.pat_load = 1'b0;
    end
    if (chk) sb_q.push_back('{sel: sel, e: e});
  endtask

  task automatic run_str(input bit sel, input string ds, input string vs, input string es,
                         input bit m, input bit ov);
    for (int i = 0; i < ds.len(); i++) begin
      cyc(sel, 1'b0, ds.getc(i) == "1", vs.getc(i) == "1", m, ov, 1'b0, 4'h0, 1'b1,
          es.getc(i) == "1");
    end
  endtask

  task automatic idle(input bit sel, input bit m, input bit ov);
    cyc(sel, 1'b0, 1'b0, 1'b0, m, ov, 1'b0, 4'h0, 1'b1, 1'b0);
  endtask

  task automatic load(input bit sel, input logic [3:0] p);
    cyc(sel, 1'b0, 1'b0, 1'b0, MEALY, 1'b1, 1'b1, p, 1'b1, 1'b0);
  endtask

  // Called right after a cyc(): waits past the preceding edge, still inside this cycle.
  task automatic check_cnt(input bit sel, input int exp);
    #3;
`ifdef SEQ_MATCH_CNT_EN
    if (!sel) check("match_cnt_a", 32'(bus_a.match_cnt), 32'(exp));
    else      check("match_cnt_b", 32'(bus_b.match_cnt), 32'(exp));
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    bus_a.Data_in = 1'b0; bus_a.valid = 1'b0; bus_a.MACHINE = MEALY; bus_a.OVERLAP = 1'b1;
    bus_a.pat_load = 1'b0; bus_a.pat_in = 4'h0;
    bus_b.Data_in = 1'b0; bus_b.valid = 1'b0; bus_b.MACHINE = MEALY; bus_b.OVERLAP = 1'b1;
    bus_b.pat_load = 1'b0; bus_b.pat_in = 2'h0;

    // Reset held two cycles, then released.
    cyc(1'b0, 1'b1, 1'b0, 1'b0, MEALY, 1'b1, 1'b0, 4'h0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, MEALY, 1'b1, 1'b0, 4'h0, 1'b1, 1'b0);
    idle(1'b0, MEALY, 1'b1);
    #3;
    check("pat_after_reset", 32'(dut_a.pat_q), 32'h9);
    check_cnt(1'b0, 0);

    // Base stream 1010001001001101: Mealy overlap hits bits 10 and 13.
    run_str(1'b0, "1010001001001101", "1111111111111111", "0000000001001000", MEALY, 1'b1);
    idle(1'b0, MEALY, 1'b1);
    check_cnt(1'b0, 2);

    // Mealy without overlap: only bit 10.
    load(1'b0, 4'b1001);
    run_str(1'b0, "1010001001001101", "1111111111111111", "0000000001000000", MEALY, 1'b0);
    idle(1'b0, MEALY, 1'b0);
    check_cnt(1'b0, 1);

    // Moore with overlap: one-cycle pulses after bits 10 and 13.
    load(1'b0, 4'b1001);
    run_str(1'b0, "1010001001001101", "1111111111111111", "0000000000100100", MOORE, 1'b1);
    idle(1'b0, MOORE, 1'b1);
    check_cnt(1'b0, 2);

    // valid gaps; the held Data_in=1 during the second gap would complete 1001.
    load(1'b0, 4'b1001);
    run_str(1'b0, "100011", "101101", "000001", MEALY, 1'b1);
    idle(1'b0, MEALY, 1'b1);
    check_cnt(1'b0, 1);

    // pat_load of 1101 on bit 3 discards that bit and clears the counter.
    run_str(1'b0, "11", "11", "00", MEALY, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, MEALY, 1'b1, 1'b1, 4'b1101, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, MEALY, 1'b1, 1'b0, 4'h0, 1'b1, 1'b0);
    check_cnt(1'b0, 0);
    run_str(1'b0, "101", "111", "001", MEALY, 1'b1);
    idle(1'b0, MEALY, 1'b1);
    check_cnt(1'b0, 1);

    // Final bit of 1101 coincides with pat_load in Moore mode: no pulse follows.
    run_str(1'b0, "10", "11", "00", MEALY, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, MOORE, 1'b1, 1'b1, 4'b1101, 1'b1, 1'b0);
    idle(1'b0, MOORE, 1'b1);
    check_cnt(1'b0, 0);

    // Instance B, pattern 11, overlap: hits on bits 2..6, counter saturates at 3.
    run_str(1'b1, "1111", "1111", "0111", MEALY, 1'b1);
    cyc(1'b1, 1'b0, 1'b1, 1'b1, MEALY, 1'b1, 1'b0, 4'h0, 1'b1, 1'b1);
    check_cnt(1'b1, 3);
    cyc(1'b1, 1'b0, 1'b1, 1'b1, MEALY, 1'b1, 1'b0, 4'h0, 1'b1, 1'b1);
    idle(1'b1, MEALY, 1'b1);
    check_cnt(1'b1, 3);

    // Reset mid-pattern: history lost, so the first new bit cannot match.
    cyc(1'b1, 1'b1, 1'b1, 1'b1, MEALY, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
    run_str(1'b1, "11", "11", "01", MEALY, 1'b1);
    idle(1'b1, MEALY, 1'b1);
    check_cnt(1'b1, 1);

    repeat (2) @(negedge clk);
    #4;
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/seq_detect_param.md
# seq_detect_param

Parametrised serial pattern detector: successor to the fixed-pattern `seq_detect`, generalised to an N-bit pattern that is loaded at run time, with a data-valid qualifier and an optional saturating match counter. It accepts one bit per qualified clock and flags when the most recent `PAT_W` accepted bits equal the loaded pattern. The first accepted bit is compared to the pattern MSB. Mealy/Moore output style and overlap mode remain run-time selectable. It sits between a serial bit source (deserialiser, UART RX) and control logic that consumes match pulses.

## Interface
Parameters:
- `PAT_W`, 4: pattern length in bits; legal range 2..32.
- `CNT_W`, 8: match counter width; used only when the counter is compiled in.
- `PAT_RST`, 4'b1001: pattern value after reset, `PAT_W` bits.

Ports (one clock; reset is synchronous and active-high):
- `clk`, input, 1: clock, rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `Data_in`, input, 1: serial data bit.
- `valid`, input, 1: `Data_in` is accepted this cycle.
- `MACHINE`, input, 1: 0 selects Mealy output, 1 selects Moore output.
- `OVERLAP`, input, 1: 1 means overlapping matches are allowed.
- `pat_load`, input, 1: single-cycle strobe that loads `pat_in`.
- `pat_in`, input, `PAT_W`: new pattern.
- `out`, output, 1: match indication.
- `match_cnt`, output, `CNT_W`: saturating match count (only with `SEQ_MATCH_CNT_EN`).

## Operation
- State held in the block:
  - `pat`: the pattern register.
  - `hist`: the last `PAT_W-1` accepted bits.
  - `fill`: count of valid history bits, 0..`PAT_W-1`.
  - `moore_q`: the registered match.
  - `match_cnt`.
- Match term: `hit = valid & (fill == PAT_W-1) & ({hist, Data_in} == pat) & ~pat_load`.
- Accepted bit (`valid=1`, `pat_load=0`):
  - The bit shifts into the `hist` LSB.
  - `fill` increments and saturates at `PAT_W-1`.
- On `hit`, `OVERLAP` is sampled in that same cycle:
  - `OVERLAP=1`: history shifts normally and `fill` stays saturated.
  - `OVERLAP=0`: `fill` is cleared to 0, so the next match needs `PAT_W` fresh bits.
- `valid=0`: no shift, `fill` holds, `hit=0`.
- `pat_load=1`:
  - `pat <= pat_in`; `fill <= 0`; `moore_q <= 0`; `match_cnt <= 0`.
  - A simultaneous `valid` bit is discarded; `pat_load` has priority.
- Output select:
  - Mealy (`MACHINE=0`): `out = hit`, combinational from `Data_in` and `valid`.
  - Moore (`MACHINE=1`): `out = moore_q`, where `moore_q <= hit` every cycle.
  - `moore_q` is computed regardless of `MACHINE`; changing `MACHINE` only switches the output mux.
- `match_cnt`:
  - Increments on each `hit`.
  - Saturates at 2^`CNT_W`-1 and does not wrap.
- Reset values: `pat=PAT_RST`, `hist=0`, `fill=0`, `moore_q=0`, `out=0` (in both modes, since `fill=0`), `match_cnt=0`.

## Timing
- Mealy latency is 0: `out` is high in the same cycle as the final pattern bit. Upstream must drive `Data_in` and `valid` stable before the rising edge (bench drives on negedge).
- Moore latency is 1: `out` is high for one cycle, starting the cycle after the final bit.
- A match can first occur on the `PAT_W`-th accepted bit after reset or `pat_load`.
- Overlap mode can flag on consecutive accepted bits (for example, an all-ones pattern on an all-ones stream).
- Reset asserted mid-pattern takes effect at the next rising edge: partial history is lost and `out` is 0 in the following cycle in both modes.
- `pat_load` while a Moore pulse is pending: `moore_q` clears and the pulse is suppressed.

## Configuration
- `SEQ_MATCH_CNT_EN` defined:
  - The `match_cnt` port and its register exist, with the behaviour above.
- `SEQ_MATCH_CNT_EN` not defined:
  - The port is absent, `CNT_W` is unused, and no counter logic is present.
  - All other behaviour is identical.

## Structure
- Package `seq_detect_pkg` holds:
  - Mode constants `MEALY=1'b0`, `MOORE=1'b1`.
  - The default pattern constant `SEQ_PAT_DEFAULT=4'b1001`.
  - A function giving the width of `fill`, `$clog2(PAT_W)`.
- One sub-module, `seq_match_cnt`: the saturating counter, instantiated only under `SEQ_MATCH_CNT_EN`.
- Shift, fill and match logic stay in the top module.

## Test plan
All scenarios use pattern 1001 and `valid=1` unless stated. The base stream, in arrival order, is 1010001001001101.
- Reset check: hold `rst` 2 cycles, then release → `out=0`, `match_cnt=0`, `pat=1001`.
- Base stream, Mealy, `OVERLAP=1` → `out` high on bits 10 and 13; `match_cnt=2`.
- Base stream, Mealy, `OVERLAP=0` → `out` high on bit 10 only; `match_cnt=1`.
- Base stream, Moore, `OVERLAP=1` → `out` high in the cycles after bits 10 and 13, one cycle wide each.
- `valid` gaps: insert `valid=0` cycles inside 1001 → still detected, with no false match on the held `Data_in`. Then assert `pat_load` with `pat_in=4'b1101` during bit 3 → the bit is discarded, `match_cnt=0`, and stream 1101 gives one match.
- Saturation: `CNT_W=2`, pattern 11, `OVERLAP=1`, 6 ones → `match_cnt` stays at 3 after the 3rd match. Then assert `rst` mid-pattern → no match until `PAT_W` new bits have been accepted.
